// File: rtl/chaser_button_ctrl.sv
// rtl/chaser_button_ctrl.sv - button debouncer and run/pause FSM driving lightchaser.enable
// Optional auto-pause after RUN_LIMIT running clocks when CHASER_AUTO_PAUSE_EN is defined.
module chaser_button_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RUN_LIMIT       = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic enable,
    output logic press_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        PAUSED  = 1'b0,
        RUNNING = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic          sync1;
    logic          btn_s;
    logic          btn_db;
    logic [CW-1:0] cnt;
    logic          db_rise;
    logic          auto_pause;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            btn_s <= sync1;
        end
    end

    // The level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
    assign db_rise = (btn_s != btn_db) && (cnt == CNT_LAST) && btn_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_db      <= 1'b0;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            press_pulse <= db_rise;
            if (btn_s == btn_db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                btn_db <= btn_s;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

`ifdef CHASER_AUTO_PAUSE_EN
    localparam int RW = (RUN_LIMIT > 1) ? $clog2(RUN_LIMIT) : 1;
    localparam logic [RW-1:0] RUN_LAST = RW'(RUN_LIMIT - 1);

    logic [RW-1:0] run_cnt;

    // Held at zero while paused, so every entry to RUNNING starts a full window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
        end else if (state != RUNNING) begin
            run_cnt <= '0;
        end else begin
            run_cnt <= run_cnt + RW'(1);
        end
    end

    assign auto_pause = (state == RUNNING) && (run_cnt == RUN_LAST);
`else
    assign auto_pause = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PAUSED;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            PAUSED:  if (press_pulse) state_next = RUNNING;
            RUNNING: if (press_pulse || auto_pause) state_next = PAUSED;
            default: state_next = PAUSED;
        endcase
    end

    assign enable = (state == RUNNING);

endmodule

// File: tb/tb_chaser_button_ctrl.sv
// tb/tb_chaser_button_ctrl.sv - self-checking bench for chaser_button_ctrl
module tb_chaser_button_ctrl;

    localparam int DB = 4;
    localparam int RL = 20;
`ifdef CHASER_AUTO_PAUSE_EN
    localparam bit AP = 1'b1;
`else
    localparam bit AP = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic btn_raw;
    logic enable;
    logic press_pulse;

    chaser_button_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .RUN_LIMIT      (RL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .enable     (enable),
        .press_pulse(press_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: btn_s is btn_raw two clocks late; the debounced level flips once the
    // last DB samples of btn_s all disagree with it; a press toggles run state and
    // a run of RL high cycles forces a pause.
    logic          m_sync1, m_btn_s, m_db, m_pulse, m_en;
    logic [DB-1:0] m_hist;
    int            m_on;

    always @(posedge clk or negedge rst_n) begin : model
        logic [DB-1:0] hn;
        logic          flip;
        logic          en_n;
        if (!rst_n) begin
            m_sync1 <= 1'b0;
            m_btn_s <= 1'b0;
            m_hist  <= '0;
            m_db    <= 1'b0;
            m_pulse <= 1'b0;
            m_en    <= 1'b0;
            m_on    <= 0;
        end else begin
            hn   = {m_hist[DB-2:0], m_btn_s};
            flip = m_db ? (hn == '0) : (hn == '1);
            en_n = m_pulse ? ~m_en : m_en;
            if (AP && m_en && (m_on + 1 >= RL)) en_n = 1'b0;
            m_sync1 <= btn_raw;
            m_btn_s <= m_sync1;
            m_hist  <= hn;
            m_db    <= m_db ^ flip;
            m_pulse <= flip & ~m_db;
            m_en    <= en_n;
            m_on    <= (en_n && m_en) ? m_on + 1 : 0;
        end
    end

    int    n_cmp = 0;
    int    n_bad = 0;
    int    lit_seq = 0;
    int    lit_done = 0;
    string lit_name;
    int    lit_act;
    int    lit_exp;

    always @(negedge clk) begin
        if (rst_n) begin
            n_cmp++;
            if (enable !== m_en) begin
                n_bad++;
                $display("FAIL model_enable t=%0t got %0b expected %0b", $time, enable, m_en);
            end
            n_cmp++;
            if (press_pulse !== m_pulse) begin
                n_bad++;
                $display("FAIL model_press_pulse t=%0t got %0b expected %0b", $time, press_pulse, m_pulse);
            end
        end
        if (lit_seq != lit_done) begin
            lit_done = lit_seq;
            n_cmp++;
            if (lit_act != lit_exp) begin
                n_bad++;
                $display("FAIL %s t=%0t got %0d expected %0d", lit_name, $time, lit_act, lit_exp);
            end
        end
    end

    task automatic post(input string nm, input int act, input int exp);
        lit_name = nm;
        lit_act  = act;
        lit_exp  = exp;
        lit_seq++;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int pc;
    int hc;

    initial begin
        rst_n   = 1'b0;
        btn_raw = 1'b0;
        step(4);
        rst_n = 1'b1;
        step(10);
        post("reset_idle", {enable, press_pulse}, 0);
        step(1);

        // Clean press: pulse at edge 6, enable at edge 7; values are {enable,press_pulse}.
        btn_raw = 1'b1;
        step(5);
        post("press_e5", {enable, press_pulse}, 0);
        step(1);
        post("press_e6", {enable, press_pulse}, 1);
        step(1);
        post("press_e7", {enable, press_pulse}, 2);
        step(1);
        btn_raw = 1'b0;
        step(10);

        pc = 0;
        for (int i = 0; i < 20; i++) begin
            btn_raw = ((i / 2) % 2 == 0);
            step(1);
            pc += int'(press_pulse);
        end
        btn_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            pc += int'(press_pulse);
        end
        post("bounce_pulses", pc, 0);
        step(1);
        post("bounce_enable", int'(enable), AP ? 0 : 1);
        step(1);

        pc = 0;
        btn_raw = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (i == 8) btn_raw = 1'b0;
            step(1);
            pc += int'(press_pulse);
        end
        post("press2_pulses", pc, 1);
        step(1);
        post("press2_enable", int'(enable), AP ? 1 : 0);
        step(30);
        post("norm1_enable", int'(enable), 0);
        step(1);

        // Async reset between edges while running, button still held.
        btn_raw = 1'b1;
        step(10);
        post("run_before_rst", int'(enable), 1);
        step(1);
        #2 rst_n = 1'b0;
        #1 post("async_rst_enable", int'(enable), 0);
        #3 rst_n = 1'b1;
        pc = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            pc += int'(press_pulse);
        end
        post("rst_repress_pulses", pc, 1);
        step(1);
        post("rst_repress_enable", int'(enable), 1);
        btn_raw = 1'b0;
        step(40);
        post("norm2_enable", int'(enable), AP ? 0 : 1);
        step(1);

`ifdef CHASER_AUTO_PAUSE_EN
        hc = 0;
        btn_raw = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (i == 7) btn_raw = 1'b0;
            hc += int'(enable);
        end
        post("auto_high_cycles", hc, RL);
        step(10);

        // Second press lands on the last running cycle: still ends PAUSED.
        btn_raw = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            step(1);
            if (e == 8) btn_raw = 1'b0;
            if (e == 20) btn_raw = 1'b1;
            if (e == 30) btn_raw = 1'b0;
            if (e == 26) post("coinc_e26", {enable, press_pulse}, 3);
            if (e == 27) post("coinc_e27", {enable, press_pulse}, 0);
        end
        post("coinc_end_enable", int'(enable), 0);
`else
        hc = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            hc += int'(enable);
        end
        post("hold_high_cycles", hc, 100);
`endif
        step(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
